// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the scan-code receiver.
//   ps2_tx_state_e : host-to-device transmit FSM states
//   PS2_CMD_*      : common host command bytes
//   PS2_RSP_ACK    : device acknowledge byte
//   odd_parity()   : PS/2 frame parity bit for a data byte
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StShift,
    StAck,
    StWaitIdle,
    StErr
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

  // Parity bit that makes the 9-bit {parity, data} word contain an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditioning for one PS/2 pad input: 2-flop synchronizer, then a level filter that only
// changes its output after FILTER_CYCLES consecutive samples of the new value.
//   clk   : system clock
//   rst   : synchronous active-high reset (filtered level resets to the idle-high value)
//   pad   : raw asynchronous pad input
//   level : filtered line level
//   fall  : one-cycle strobe on a filtered 1->0 transition
module ps2_line_filter #(
  parameter int unsigned FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic fall
);

  localparam int unsigned CntW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FILTER_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q;
  logic            fall_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pad;
      sync2_q <= sync1_q;
      fall_q  <= 1'b0;
      if (sync2_q == level_q) begin
        // Any sample matching the current level restarts the run.
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        level_q <= sync2_q;
        fall_q  <= level_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the attached device and
// reports ACK (tx_done), or NACK/timeout (tx_err). The pad tristates live at chip level
// as PS2_CLK = ps2_clk_oe ? 1'b0 : 1'bz (likewise PS2_DATA).
//   clk, rst     : system clock, synchronous active-high reset
//   tx_valid     : command byte offered (ignored while busy)
//   tx_data      : command byte
//   tx_ready     : idle, a byte is accepted on tx_valid && tx_ready
//   tx_done      : one-cycle pulse, device acknowledged the byte
//   tx_err       : one-cycle pulse, device NACK or clock timeout
//   busy         : transaction in progress; the receiver discards frames meanwhile
//   ps2_clk_i    : raw PS2_CLK pad input
//   ps2_data_i   : raw PS2_DATA pad input
//   ps2_clk_oe   : 1 pulls PS2_CLK low
//   ps2_data_oe  : 1 pulls PS2_DATA low
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned FILTER_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                     : TIMEOUT_CYCLES;
  localparam int unsigned CntW = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  logic clk_level;
  logic clk_fall;
  logic data_level;
  logic unused_data_fall;

  ps2_line_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_clk_filter (
    .clk  (clk),
    .rst  (rst),
    .pad  (ps2_clk_i),
    .level(clk_level),
    .fall (clk_fall)
  );

  ps2_line_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_data_filter (
    .clk  (clk),
    .rst  (rst),
    .pad  (ps2_data_i),
    .level(data_level),
    .fall (unused_data_fall)
  );

  ps2_tx_state_e   state_q;
  logic [CntW-1:0] cnt_q;     // inhibit length, then gap since the last device clock fall
  logic [3:0]      edge_q;    // device clock falls seen in the current frame
  logic [8:0]      frame_q;   // {parity, data}, indexed by edge_q
  logic            clk_oe_q;
  logic            data_oe_q;
  logic            ready_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic            timeout;

  assign timeout = (cnt_q == TimeoutLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      edge_q    <= '0;
      frame_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tx_valid && ready_q) begin
            frame_q  <= {odd_parity(tx_data), tx_data};
            state_q  <= StInhibit;
            clk_oe_q <= 1'b1;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
          end
        end
        StInhibit: begin
          if (cnt_q == InhibitLast) begin
            // Start bit goes low in the same cycle the clock is released.
            state_q   <= StRts;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b1;
            cnt_q     <= '0;
            edge_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StRts: begin
          state_q <= StShift;
          cnt_q   <= cnt_q + CntW'(1);
        end
        StShift: begin
          if (clk_fall) begin
            cnt_q  <= '0;
            edge_q <= edge_q + 4'd1;
            if (edge_q == 4'd9) begin
              data_oe_q <= 1'b0;  // stop bit
              state_q   <= StAck;
            end else begin
              data_oe_q <= ~frame_q[edge_q];
            end
          end else if (timeout) begin
            state_q   <= StErr;
            err_q     <= 1'b1;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StAck: begin
          if (clk_fall) begin
            cnt_q <= '0;
            if (data_level) begin
              state_q   <= StErr;
              err_q     <= 1'b1;
              clk_oe_q  <= 1'b0;
              data_oe_q <= 1'b0;
            end else begin
              state_q <= StWaitIdle;
            end
          end else if (timeout) begin
            state_q   <= StErr;
            err_q     <= 1'b1;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWaitIdle: begin
          if (done_q) begin
            // tx_done was high this cycle; ready follows in the next one.
            state_q <= StIdle;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (clk_level && data_level) begin
            done_q <= 1'b1;
          end else if (clk_fall) begin
            cnt_q <= '0;
          end else if (timeout) begin
            state_q   <= StErr;
            err_q     <= 1'b1;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StErr: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready    = ready_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign busy        = busy_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on an open-drain bus.
// Frame bits and transaction outcomes are queued when a byte is offered and checked as the
// device samples them / as tx_done or tx_err pulses.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH  = 120;
  localparam int unsigned FLT  = 4;
  localparam int unsigned TMO  = 400;
  localparam int          HALF = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_done, tx_err, busy;
  logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  // Open-drain bus: either side pulling low wins.
  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .FILTER_CYCLES (FLT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .busy       (busy),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_done = 0;
  int n_err = 0;
  always @(negedge clk) begin
    if (tx_done) n_done <= n_done + 1;
    if (tx_err) n_err <= n_err + 1;
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_bits[$];
  int   exp_res[$];   // 1 = tx_done, 2 = tx_err

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want)
    else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic check_bit(input string tag, input logic got);
    logic want;
    check({tag, "_queued"}, 32'(exp_bits.size() > 0), 1);
    if (exp_bits.size() > 0) begin
      want = exp_bits.pop_front();
      check(tag, 32'(got), 32'(want));
    end
  endtask

  function automatic logic ref_parity(input logic [7:0] b);
    int ones = 0;
    for (int k = 0; k < 8; k++) if (b[k]) ones++;
    return (ones % 2) == 0;
  endfunction

  // {tx_done, tx_err, tx_ready, busy, ps2_clk_oe, ps2_data_oe} when idle
  localparam logic [5:0] IdleVec = 6'b001000;

  task automatic offer(input logic [7:0] b, input int res, output int waited);
    tx_valid = 1'b1;
    tx_data  = b;
    exp_bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) exp_bits.push_back(b[k]);
    exp_bits.push_back(ref_parity(b));
    exp_bits.push_back(1'b1);
    if (res != 0) exp_res.push_back(res);
    waited = 0;
    while (!tx_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    check("accept_busy_clkoe", {30'd0, busy, ps2_clk_oe}, 32'd3);
  endtask

  task automatic wait_result(input string tag, input int limit);
    int i = 0;
    int want;
    while (!(tx_done || tx_err) && i < limit) begin
      @(negedge clk);
      i++;
    end
    want = (exp_res.size() > 0) ? exp_res.pop_front() : 0;
    check({tag, "_result"}, {30'd0, tx_err, tx_done}, 32'(want));
    check({tag, "_oes_at_pulse"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
  endtask

  task automatic after_pulse(input string tag);
    @(negedge clk);
    check({tag, "_after"}, {26'd0, tx_done, tx_err, tx_ready, busy, ps2_clk_oe, ps2_data_oe},
          32'(IdleVec));
  endtask

  // Device model: measures the inhibit, then clocks the frame, sampling data on rising edges.
  task automatic kbd(input int stop_after, input bit nack, input bit glitch,
                     output int last_fall);
    int cnt = 0;
    last_fall = 0;
    while (ps2_clk_oe && cnt < int'(INH) + 10) begin
      cnt++;
      @(negedge clk);
    end
    check("inhibit_len", cnt, INH);
    check("start_oe", 32'(ps2_data_oe), 1);
    check_bit("start_bit", ps2_data_i);
    repeat (20) @(negedge clk);
    for (int i = 1; i <= 11; i++) begin
      dev_clk_low = 1'b1;
      last_fall   = cyc;
      if (i == 11 && nack) return;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i <= 10) check_bit($sformatf("frame_bit%0d", i), ps2_data_i);
      if (i == 10 && !nack) dev_data_low = 1'b1;
      if (i == stop_after) return;
      if (glitch && (i == 3 || i == 7)) begin
        repeat (8) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF - 11) @(negedge clk);
      end else if (glitch && i == 4) begin
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        @(negedge clk);
        check("stray_ready", 32'(tx_ready), 0);
        tx_valid = 1'b0;
        repeat (HALF - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    dev_data_low = 1'b0;
  endtask

  initial begin
    int w;
    int lf;
    int d0;
    int e0;

    repeat (3) @(negedge clk);
    check("reset_state", {26'd0, tx_done, tx_err, tx_ready, busy, ps2_clk_oe, ps2_data_oe},
          32'(IdleVec));
    rst = 1'b0;
    @(negedge clk);
    check("post_reset", {26'd0, tx_done, tx_err, tx_ready, busy, ps2_clk_oe, ps2_data_oe},
          32'(IdleVec));

    // Plain send with ACK.
    offer(PS2_CMD_ENABLE, 1, w);
    kbd(0, 1'b0, 1'b0, lf);
    wait_result("f4", 100);
    after_pulse("f4");

    // Back-to-back: second byte offered in the done cycle, accepted on the first idle cycle.
    offer(PS2_CMD_SET_LED, 1, w);
    kbd(0, 1'b0, 1'b0, lf);
    wait_result("ed", 100);
    offer(8'h00, 1, w);
    check("b2b_gap", w, 1);
    kbd(0, 1'b0, 1'b0, lf);
    wait_result("00", 100);
    after_pulse("00");

    // NACK: data left high at the 11th falling edge.
    offer(PS2_CMD_ENABLE, 2, w);
    kbd(0, 1'b1, 1'b0, lf);
    wait_result("nack", 100);
    dev_clk_low = 1'b0;
    after_pulse("nack");
    repeat (20) @(negedge clk);

    // Timeout: device stops after 4 falls. The filtered fall reaches the FSM FLT+3 cycles
    // after the pad edge, and the gap counter runs from there.
    offer(PS2_CMD_SET_LED, 2, w);
    kbd(4, 1'b0, 1'b0, lf);
    wait_result("tmo", int'(TMO) + 100);
    check("tmo_latency", cyc - lf, TMO + FLT + 3);
    after_pulse("tmo");
    exp_bits.delete();

    // Reset in the middle of the frame.
    d0 = n_done;
    e0 = n_err;
    offer(PS2_CMD_RESET, 0, w);
    kbd(6, 1'b0, 1'b0, lf);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_reset", {26'd0, tx_done, tx_err, tx_ready, busy, ps2_clk_oe, ps2_data_oe},
          32'(IdleVec));
    exp_bits.delete();
    repeat (10) @(negedge clk);
    check("rst_no_done", n_done, d0);
    check("rst_no_err", n_err, e0);
    offer(PS2_CMD_RESET, 1, w);
    kbd(0, 1'b0, 1'b0, lf);
    wait_result("ff", 100);
    after_pulse("ff");

    // Clock glitches and stray tx_valid during the frame.
    offer(PS2_CMD_ENABLE, 1, w);
    kbd(0, 1'b0, 1'b1, lf);
    wait_result("glitch", 100);
    after_pulse("glitch");
    repeat (5) @(negedge clk);
    check("stray_not_taken", {26'd0, tx_done, tx_err, tx_ready, busy, ps2_clk_oe, ps2_data_oe},
          32'(IdleVec));

    check("total_done", n_done, 5);
    check("total_err", n_err, 2);
    check("results_drained", exp_res.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
